// File: rtl/instruction_sequencer.sv
// Microcode sequencer: fetches from a synchronous instruction RAM, forwards datapath
// opcodes to the MasterController bus and executes loop/wait/halt opcodes internally.
module instruction_sequencer #(
  parameter int depth     = 2,
  parameter int D         = 1 << depth,
  parameter int W         = 16,
  parameter int insW      = (depth > 2) ? depth : 2,
  parameter int insD      = (D > W) ? D : W,
  parameter int insWidth  = 4 + 2 + 2 * insW + insD,
  parameter int PcW       = 10,
  parameter int LoopDepth = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [PcW-1:0]      startAddr,
  input  logic                abort,
  output logic [PcW-1:0]      imemAddr,
  output logic                imemEn,
  input  logic [insWidth-1:0] imemData,
  output logic [insWidth-1:0] instruction,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int SpW  = $clog2(LoopDepth + 1);
  localparam int StkN = 1 << SpW;

  localparam logic [3:0] OP_NOP   = 4'b0100;
  localparam logic [3:0] OP_LOOP  = 4'b0101;
  localparam logic [3:0] OP_ENDL  = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b0111;
  localparam logic [3:0] OP_WAIT  = 4'b1101;
  localparam logic [insWidth-1:0] NOP_WORD = {OP_NOP, {(insWidth-4){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PcW-1:0]      pc_q, pc_d;
  logic [SpW-1:0]      sp_q, sp_d;
  logic [PcW-1:0]      stk_start_q [StkN];
  logic [PcW-1:0]      stk_start_d [StkN];
  logic [insD-1:0]     stk_cnt_q [StkN];
  logic [insD-1:0]     stk_cnt_d [StkN];
  logic [insD-1:0]     wait_cnt_q, wait_cnt_d;
  logic [insWidth-1:0] instr_q, instr_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;

  logic [3:0]          opcode;
  logic [insD-1:0]     count;
  logic [SpW-1:0]      sp_top;
  logic [PcW-1:0]      pc_inc;
  logic                advance;

  assign opcode = imemData[insWidth-1 -: 4];
  assign count  = imemData[insD-1:0];
  assign sp_top = sp_q - SpW'(1);
  assign pc_inc = pc_q + PcW'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    stk_start_d = stk_start_q;
    stk_cnt_d   = stk_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    instr_d     = NOP_WORD;
    busy_d      = busy_q;
    error_d     = error_q;
    imemEn      = 1'b0;
    imemAddr    = '0;
    done        = (state_q == S_DONE);
    advance     = 1'b0;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      sp_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = startAddr;
            error_d = 1'b0;
            busy_d  = 1'b1;
            sp_d    = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          imemEn   = 1'b1;
          imemAddr = pc_q;
          state_d  = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          advance = 1'b1;
          case (opcode)
            OP_NOP: ;
            OP_HALT: begin
              state_d = S_DONE;
              advance = 1'b0;
            end
            OP_WAIT: begin
              wait_cnt_d = count;
              if (count != '0) state_d = S_WAIT;
            end
            OP_LOOP: begin
              if (sp_q == SpW'(LoopDepth)) begin
                error_d = 1'b1;
                state_d = S_DONE;
                advance = 1'b0;
              end else begin
                // stored count is remaining repeats, so LOOP 0 and LOOP 1 both run once
                stk_start_d[sp_q] = pc_inc;
                stk_cnt_d[sp_q]   = (count == '0) ? '0 : count - insD'(1);
                sp_d              = sp_q + SpW'(1);
              end
            end
            OP_ENDL: begin
              if (sp_q == '0) begin
                error_d = 1'b1;
                state_d = S_DONE;
                advance = 1'b0;
              end else if (stk_cnt_q[sp_top] != '0) begin
                stk_cnt_d[sp_top] = stk_cnt_q[sp_top] - insD'(1);
                pc_d              = stk_start_q[sp_top];
                advance           = 1'b0;
              end else begin
                sp_d = sp_top;
              end
            end
            default: instr_d = imemData;
          endcase
          if (advance) begin
            if (pc_q == '1) begin
              error_d = 1'b1;
              state_d = S_DONE;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        S_WAIT: begin
          wait_cnt_d = wait_cnt_q - insD'(1);
          if (wait_cnt_q == insD'(1)) state_d = S_FETCH;
        end
        S_DONE: begin
          busy_d  = 1'b0;
          sp_d    = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      wait_cnt_q <= '0;
      instr_q    <= NOP_WORD;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      for (int i = 0; i < StkN; i++) begin
        stk_start_q[i] <= '0;
        stk_cnt_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_q     <= instr_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      stk_start_q <= stk_start_d;
      stk_cnt_q   <= stk_cnt_d;
    end
  end

  assign instruction = instr_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule
